// File: rtl/regfile_pkg.sv
// Shared constants and the writeback request type used by the arbiter and its FIFO.
package regfile_pkg;

   localparam int WORD   = 32;
   localparam int ADDR_W = 5;

   // One register-file write: destination register and value.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [WORD-1:0]   data;
   } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small in-order buffer for multi-cycle-unit results awaiting the register-file port.
// The head entry is readable combinationally so it can be written in the same cycle it is selected.
module wb_fifo
   import regfile_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_push,
   input  wb_req_t          i_data,
   input  logic             i_pop,
   output wb_req_t          o_head,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   wb_req_t          r_mem [DEPTH];

   logic w_do_push;
   logic w_do_pop;

   // Pointers wrap at DEPTH-1 so non-power-of-two depths work too.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rd_ptr];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   // Pointer and occupancy bookkeeping; reset drops every buffered entry.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage; contents are don't-care until written.
   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the single register-file write port between the main pipeline writeback and
// buffered multi-cycle-unit results, with a starvation guard and a pending-register
// scoreboard that drives the decode hazard stall.
module regfile_wb_arbiter #(
   parameter int WORD       = regfile_pkg::WORD,
   parameter int ADDR_W     = regfile_pkg::ADDR_W,
   parameter int FIFO_DEPTH = 2,
   parameter int MAX_WAIT   = 3
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_wb_we,
   input  logic [ADDR_W-1:0] i_wb_addr,
   input  logic [WORD-1:0]   i_wb_data,
   input  logic              i_mdu_valid,
   input  logic [ADDR_W-1:0] i_mdu_addr,
   input  logic [WORD-1:0]   i_mdu_data,
   output logic              o_mdu_ready,
   input  logic              i_issue_valid,
   input  logic [ADDR_W-1:0] i_issue_rd,
   input  logic [ADDR_W-1:0] i_chk_rs1,
   input  logic [ADDR_W-1:0] i_chk_rs2,
   input  logic [ADDR_W-1:0] i_chk_rd,
   output logic              o_hazard_stall,
   output logic              o_pipe_stall,
   output logic              o_rf_we,
   output logic [ADDR_W-1:0] o_rf_addr,
   output logic [WORD-1:0]   o_rf_data
);
   import regfile_pkg::*;

   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam int NREG   = 2 ** ADDR_W;

   wb_req_t          w_push_data;
   wb_req_t          w_head;
   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic [CNT_W-1:0] w_count;
   logic             w_unused_full;

   logic             w_head_valid;
   logic             w_head_zero;
   logic             w_main_valid;
   logic             w_starve;
   logic             w_main_wins;
   logic             w_head_write;

   logic [WAIT_W-1:0] r_wait_cnt;
   logic [NREG-1:0]   r_pending;
   logic [NREG-1:0]   w_pending_next;

   // ---------------- result buffer ----------------
   assign w_push_data   = '{addr: i_mdu_addr, data: i_mdu_data};
   assign o_mdu_ready   = (w_count < CNT_W'(FIFO_DEPTH)) && !i_reset;
   assign w_push        = i_mdu_valid && o_mdu_ready;
   assign w_unused_full = w_full;

   wb_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (w_push),
      .i_data  (w_push_data),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // ---------------- port arbitration ----------------
   // Writes to x0 never take the port; an x0 head is simply dropped on arrival.
   assign w_head_valid = !w_empty;
   assign w_head_zero  = (w_head.addr == '0);
   assign w_main_valid = i_wb_we && (i_wb_addr != '0);
   assign w_starve     = (r_wait_cnt == WAIT_W'(MAX_WAIT)) && w_head_valid;
   assign w_main_wins  = w_main_valid && !w_starve;
   assign w_head_write = w_head_valid && !w_head_zero && !w_main_wins;
   assign w_pop        = w_head_valid && (w_head_zero || !w_main_wins);
   assign o_pipe_stall = w_starve && w_main_valid;

   // Select the single source driving the register-file write port this cycle.
   always_comb begin
      o_rf_we   = 1'b0;
      o_rf_addr = '0;
      o_rf_data = '0;
      if (i_reset) begin
         o_rf_we = 1'b0;
      end else if (w_main_wins) begin
         o_rf_we   = 1'b1;
         o_rf_addr = i_wb_addr;
         o_rf_data = i_wb_data;
      end else if (w_head_write) begin
         o_rf_we   = 1'b1;
         o_rf_addr = w_head.addr;
         o_rf_data = w_head.data;
      end
   end

   // Count how long the current head has been denied the port, saturating at the limit.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_wait_cnt <= '0;
      end else if (w_pop || w_empty) begin
         r_wait_cnt <= '0;
      end else if (r_wait_cnt != WAIT_W'(MAX_WAIT)) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end

   // ---------------- pending-register scoreboard ----------------
   // A new issue to a register wins over a same-cycle retirement of that register.
   assign w_pending_next[0] = 1'b0;
   for (genvar gi = 1; gi < NREG; gi++) begin : g_pending
      assign w_pending_next[gi] =
         (i_issue_valid && (i_issue_rd == ADDR_W'(gi))) ? 1'b1 :
         (w_head_write && (w_head.addr == ADDR_W'(gi))) ? 1'b0 :
         r_pending[gi];
   end

   // Scoreboard state register.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_pending <= '0;
      end else begin
         r_pending <= w_pending_next;
      end
   end

   assign o_hazard_stall = ((i_chk_rs1 != '0) && r_pending[i_chk_rs1]) ||
                           ((i_chk_rs2 != '0) && r_pending[i_chk_rs2]) ||
                           ((i_chk_rd  != '0) && r_pending[i_chk_rd]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: main writeback, MDU path, starvation,
// full buffer, x0 handling, scoreboard set/clear priority and mid-operation reset.
module tb_regfile_wb_arbiter;

   logic        clk;
   logic        reset;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        mdu_valid;
   logic [4:0]  mdu_addr;
   logic [31:0] mdu_data;
   logic        mdu_ready;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [4:0]  chk_rs1;
   logic [4:0]  chk_rs2;
   logic [4:0]  chk_rd;
   logic        hazard_stall;
   logic        pipe_stall;
   logic        rf_we;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;

   int errors;
   int checks;

   regfile_wb_arbiter #(
      .WORD       (32),
      .ADDR_W     (5),
      .FIFO_DEPTH (2),
      .MAX_WAIT   (3)
   ) dut (
      .i_clk          (clk),
      .i_reset        (reset),
      .i_wb_we        (wb_we),
      .i_wb_addr      (wb_addr),
      .i_wb_data      (wb_data),
      .i_mdu_valid    (mdu_valid),
      .i_mdu_addr     (mdu_addr),
      .i_mdu_data     (mdu_data),
      .o_mdu_ready    (mdu_ready),
      .i_issue_valid  (issue_valid),
      .i_issue_rd     (issue_rd),
      .i_chk_rs1      (chk_rs1),
      .i_chk_rs2      (chk_rs2),
      .i_chk_rd       (chk_rd),
      .o_hazard_stall (hazard_stall),
      .o_pipe_stall   (pipe_stall),
      .o_rf_we        (rf_we),
      .o_rf_addr      (rf_addr),
      .o_rf_data      (rf_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "bench did not finish");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mdu_offer(input logic [4:0] a, input logic [31:0] d);
      mdu_valid = 1'b1;
      mdu_addr  = a;
      mdu_data  = d;
   endtask

   task automatic main_wr(input logic we, input logic [4:0] a, input logic [31:0] d);
      wb_we   = we;
      wb_addr = a;
      wb_data = d;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset = 1'b1;
      main_wr(1'b0, 5'd0, 32'h0);
      mdu_valid = 1'b0; mdu_addr = 5'd0; mdu_data = 32'h0;
      issue_valid = 1'b0; issue_rd = 5'd0;
      chk_rs1 = 5'd0; chk_rs2 = 5'd0; chk_rd = 5'd0;

      // Reset state
      #2;
      chk("rst_rf_we", rf_we, 0);
      chk("rst_mdu_ready", mdu_ready, 0);
      chk("rst_hazard", hazard_stall, 0);
      chk("rst_pipe_stall", pipe_stall, 0);
      #10 reset = 1'b0;

      // Main write only, same-cycle pass-through
      tick();
      main_wr(1'b1, 5'd5, 32'hDEADBEEF);
      #1;
      chk("main_rf_we", rf_we, 1);
      chk("main_rf_addr", rf_addr, 5);
      chk("main_rf_data", rf_data, 32'hDEADBEEF);
      chk("main_mdu_ready", mdu_ready, 1);

      // Issue rd=7; hazard appears the following cycle
      tick();
      main_wr(1'b0, 5'd0, 32'h0);
      issue_valid = 1'b1; issue_rd = 5'd7; chk_rs1 = 5'd7;
      #1;
      chk("issue_hazard_same_cycle", hazard_stall, 0);
      tick();
      issue_valid = 1'b0;
      #1;
      chk("pending7_hazard_rs1", hazard_stall, 1);
      chk("idle_rf_we", rf_we, 0);
      chk_rs1 = 5'd0; chk_rd = 5'd7;
      #1;
      chk("pending7_hazard_rd", hazard_stall, 1);
      chk_rs1 = 5'd7; chk_rd = 5'd0;
      mdu_offer(5'd7, 32'h12345678);
      #1;
      chk("mdu7_ready", mdu_ready, 1);
      tick();
      mdu_valid = 1'b0;
      #1;
      chk("mdu7_rf_we", rf_we, 1);
      chk("mdu7_rf_addr", rf_addr, 7);
      chk("mdu7_rf_data", rf_data, 32'h12345678);
      chk("mdu7_hazard_still", hazard_stall, 1);
      tick();
      #1;
      chk("mdu7_hazard_cleared", hazard_stall, 0);
      chk("mdu7_rf_we_done", rf_we, 0);
      chk_rs1 = 5'd0;

      // Starvation: 9/0xA5 buffered while main writes x3 every cycle
      tick();
      main_wr(1'b1, 5'd3, 32'h33333333);
      mdu_offer(5'd9, 32'h000000A5);
      #1;
      chk("starve_push_rf_addr", rf_addr, 3);
      tick();
      mdu_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("starve_main_%0d_addr", i), rf_addr, 3);
         chk($sformatf("starve_main_%0d_stall", i), pipe_stall, 0);
         tick();
      end
      #1;
      chk("starve_rf_addr", rf_addr, 9);
      chk("starve_rf_data", rf_data, 32'h000000A5);
      chk("starve_pipe_stall", pipe_stall, 1);

      // Main resumes; fill the buffer while main keeps the port busy
      tick();
      mdu_offer(5'd10, 32'h00000100);
      #1;
      chk("resume_rf_addr", rf_addr, 3);
      chk("resume_pipe_stall", pipe_stall, 0);
      chk("full_ready0", mdu_ready, 1);
      tick();
      mdu_offer(5'd11, 32'h00000101);
      #1;
      chk("full_ready1", mdu_ready, 1);
      chk("full_rf_addr1", rf_addr, 3);
      tick();
      mdu_offer(5'd12, 32'h00000102);
      #1;
      chk("full_ready_low", mdu_ready, 0);
      chk("full_rf_addr2", rf_addr, 3);
      tick();
      #1;
      chk("full_ready_low2", mdu_ready, 0);
      chk("full_rf_addr3", rf_addr, 3);
      tick();
      #1;
      chk("full_head10_addr", rf_addr, 10);
      chk("full_head10_data", rf_data, 32'h00000100);
      chk("full_head10_stall", pipe_stall, 1);
      chk("full_no_push_pop", mdu_ready, 0);
      tick();
      main_wr(1'b0, 5'd0, 32'h0);
      #1;
      chk("full_head11_addr", rf_addr, 11);
      chk("full_head11_data", rf_data, 32'h00000101);
      chk("full_ready_again", mdu_ready, 1);
      tick();
      mdu_valid = 1'b0;
      #1;
      chk("full_head12_addr", rf_addr, 12);
      chk("full_head12_data", rf_data, 32'h00000102);
      tick();
      #1;
      chk("full_drained_we", rf_we, 0);

      // x0: main write to x0 leaves the port to the MDU head
      mdu_offer(5'd13, 32'h00000013);
      tick();
      mdu_valid = 1'b0;
      main_wr(1'b1, 5'd0, 32'hFFFFFFFF);
      #1;
      chk("x0_main_rf_we", rf_we, 1);
      chk("x0_main_rf_addr", rf_addr, 13);
      chk("x0_main_rf_data", rf_data, 32'h00000013);
      chk("x0_main_pipe_stall", pipe_stall, 0);
      tick();
      main_wr(1'b0, 5'd0, 32'h0);
      mdu_offer(5'd0, 32'h00000077);
      #1;
      chk("x0_mdu_ready", mdu_ready, 1);
      tick();
      mdu_offer(5'd14, 32'h00000014);
      #1;
      chk("x0_mdu_no_write", rf_we, 0);
      tick();
      mdu_valid = 1'b0;
      #1;
      chk("x0_next_rf_addr", rf_addr, 14);
      chk("x0_next_rf_data", rf_data, 32'h00000014);

      // Set and clear of the same scoreboard bit in one cycle: set wins
      tick();
      mdu_offer(5'd15, 32'h00000015);
      tick();
      mdu_valid = 1'b0;
      issue_valid = 1'b1; issue_rd = 5'd15; chk_rs2 = 5'd15;
      #1;
      chk("setclr_rf_addr", rf_addr, 15);
      chk("setclr_hazard_before", hazard_stall, 0);
      tick();
      issue_valid = 1'b0;
      mdu_offer(5'd15, 32'h00000016);
      #1;
      chk("setclr_set_wins", hazard_stall, 1);
      tick();
      mdu_valid = 1'b0;
      #1;
      chk("setclr_retire_data", rf_data, 32'h00000016);
      tick();
      #1;
      chk("setclr_cleared", hazard_stall, 0);
      chk_rs2 = 5'd0;

      // Asynchronous reset with two buffered results and a pending register
      main_wr(1'b1, 5'd3, 32'h33333333);
      mdu_offer(5'd21, 32'h00000021);
      issue_valid = 1'b1; issue_rd = 5'd20; chk_rs1 = 5'd20;
      tick();
      issue_valid = 1'b0;
      mdu_offer(5'd22, 32'h00000022);
      #1;
      chk("arst_pending20", hazard_stall, 1);
      tick();
      mdu_valid = 1'b0;
      #1;
      chk("arst_full", mdu_ready, 0);
      #1 reset = 1'b1;
      #1;
      chk("arst_rf_we", rf_we, 0);
      chk("arst_mdu_ready", mdu_ready, 0);
      chk("arst_hazard", hazard_stall, 0);
      chk("arst_pipe_stall", pipe_stall, 0);
      #2 reset = 1'b0;
      main_wr(1'b0, 5'd0, 32'h0);
      tick();
      #1;
      chk("arst_after_we0", rf_we, 0);
      chk("arst_after_ready", mdu_ready, 1);
      chk("arst_after_hazard", hazard_stall, 0);
      tick();
      #1;
      chk("arst_after_we1", rf_we, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameters: WORD, 32, data width; ADDR_W, 5, register address width; FIFO_DEPTH, 2, MDU result buffer entries; MAX_WAIT, 3, cycles a buffered MDU result may be starved before the pipeline is stalled.
REQ-002 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-003 clk  input  1  clock, all state updates on posedge.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 wb_we / wb_addr / wb_data  input  1 / ADDR_W / WORD  main-pipeline writeback request.
REQ-006 mdu_valid / mdu_addr / mdu_data  input  1 / ADDR_W / WORD  multi-cycle-unit result offer.
REQ-007 mdu_ready  output  1  arbiter can accept an MDU result this cycle.
REQ-008 issue_valid / issue_rd  input  1 / ADDR_W  MDU op issued; marks issue_rd pending.
REQ-009 chk_rs1, chk_rs2, chk_rd  input  ADDR_W each  decode-stage operands to hazard-check.
REQ-010 hazard_stall  output  1  decode must stall (pending operand).
REQ-011 pipe_stall  output  1  main pipeline must hold its writeback (MDU starvation).
REQ-012 rf_we / rf_addr / rf_data  output  1 / ADDR_W / WORD  single register-file write port.

Function
REQ-013 SHALL drive rf_* combinationally each cycle from exactly one source: main writeback, FIFO head, or none (rf_we=0).
REQ-014 Requests with address 0 SHALL be discarded: never drive rf_we, never occupy the port; an MDU result to x0 SHALL still be accepted and popped.
REQ-015 Priority: main writeback (wb_we, wb_addr!=0) wins, unless starve=1, in which case FIFO head wins and pipe_stall=1.
REQ-016 pipe_stall SHALL equal starve AND wb_we AND wb_addr!=0; pipeline holds wb_* stable while pipe_stall=1.
REQ-017 Every MDU result SHALL pass through the FIFO; accept when mdu_valid && mdu_ready; minimum accept-to-rf_we latency 1 cycle.
REQ-018 mdu_ready SHALL equal (count < FIFO_DEPTH) and not reset; FIFO push and pop in the same cycle when full SHALL be disallowed (ready low when full).
REQ-019 FIFO SHALL be strictly in-order; count range 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
REQ-020 wait_cnt SHALL clear when the head is written or FIFO empty, else increment, saturating at MAX_WAIT; starve = (wait_cnt == MAX_WAIT) AND head valid.
REQ-021 Scoreboard pending[31:0]: issue_valid with issue_rd!=0 sets bit next cycle; FIFO head write clears pending[head addr].
REQ-022 Simultaneous set and clear of the same bit SHALL leave it set.
REQ-023 hazard_stall SHALL be combinational: pending[r] for any nonzero r in {chk_rs1, chk_rs2, chk_rd}; bit 0 never set.
REQ-024 Issuer SHALL assert issue_valid only when hazard_stall=0; arbiter need not detect WAW beyond REQ-023.

Reset
REQ-025 On reset: count=0, pointers=0, wait_cnt=0, pending=0; outputs rf_we=0, mdu_ready=0, hazard_stall=0, pipe_stall=0; FIFO data undefined.
REQ-026 Reset mid-operation SHALL discard buffered MDU results without any write.

Structure
REQ-027 Package regfile_pkg SHALL hold WORD, ADDR_W constants and typedef wb_req_t {addr, data}.
REQ-028 FIFO SHALL be sub-module wb_fifo (parameterised depth, wb_req_t entries, push/pop/full/empty/count).

Verification
REQ-029 Main write only: wb_we=1, addr=5, data=0xDEADBEEF -> same cycle rf_we=1, rf_addr=5, rf_data=0xDEADBEEF.
REQ-030 MDU idle port: issue rd=7; next cycle hazard_stall=1 for chk_rs1=7; push 7/0x12345678 -> rf_we next cycle with 7/0x12345678; pending[7] clears, hazard_stall=0.
REQ-031 Starvation: FIFO holds 9/0xA5, wb_we=1 every cycle to addr 3 -> main wins 3 cycles, 4th cycle rf_addr=9, pipe_stall=1; next cycle main resumes.
REQ-032 Full: two MDU pushes while wb busy -> mdu_ready=0; third offer held until pop; order preserved.
REQ-033 x0: main write addr 0 with MDU head pending -> head written same cycle; MDU result to x0 popped with rf_we=0.
REQ-034 Async reset asserted with FIFO count=2 -> outputs zero immediately; after release no write of old entries, pending=0.
